vga_scanout: RTL and testbench



---
 rtl/vga_scanout.sv | 194 +++++++++++++++++++
 tb/tb_vga_scanout.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scanout
//  Description : 160x120x3 framebuffer with a single-pixel write port and a
//                640x480@60 Hz VGA scan-out. Each framebuffer pixel is shown
//                as a 4x4 block. A one-clk vblank pulse is produced each frame.
//
//  Ports
//    clk, resetn            50 MHz clock, synchronous active-low reset
//    x, y, colour, plot     pixel write: column, row, {R,G,B}, strobe
//    wr_drop                one-clk pulse after a write with x/y out of range
//    vblank                 one-clk pulse as the raster enters vertical blank
//    VGA_CLK                25 MHz pixel clock (clk/2)
//    VGA_HS, VGA_VS         active-low syncs
//    VGA_BLANK              active-low blank (1 = visible pixel)
//    VGA_SYNC               tied to 1
//    VGA_R, VGA_G, VGA_B    colour bit replicated over 10 DAC bits
//
//  The address arithmetic uses y*160 = (y<<7)+(y<<5), so FB_W must stay 160.
//
//  Revision    : 1.0  initial release
// ============================================================================
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_W     = 160,
    parameter int FB_H     = 120
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    output logic       wr_drop,
    output logic       vblank,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK,
    output logic       VGA_SYNC,
    output logic [9:0] VGA_R,
    output logic [9:0] VGA_G,
    output logic [9:0] VGA_B
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int AW       = $clog2(FB_DEPTH);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] VBL_LINE = 10'(V_ACTIVE - 1);
    localparam logic [7:0] X_LIM    = 8'(FB_W);
    localparam logic [6:0] Y_LIM    = 7'(FB_H);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic       phase_q;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic       vblank_q;
    logic       wr_drop_q;

    // S0 flags (combinational) and their S1 copies
    logic       act_d, hs_d, vs_d;
    logic       act1_q, hs1_q, vs1_q;

    // S1 memory read data and S2 output registers
    logic [2:0] rd_q;
    logic [2:0] rgb_q;
    logic       blank_q;
    logic       hs_n_q;
    logic       vs_n_q;

    logic [2:0] mem_q [FB_DEPTH];

    logic        w_pix_en;
    logic        w_in_range;
    logic        w_wr_en;
    logic [7:0]  w_row;
    logic [7:0]  w_col;
    logic [14:0] w_rd_addr;
    logic [14:0] w_wr_addr;

    assign w_pix_en = phase_q;

    // ------------------------------------------------------------------
    // Write-side address and range check
    // ------------------------------------------------------------------
    assign w_in_range = (x < X_LIM) && (y < Y_LIM);
    assign w_wr_en    = plot && w_in_range;
    assign w_wr_addr  = ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};

    // ------------------------------------------------------------------
    // Raster next-state and S0 decode
    // ------------------------------------------------------------------
    always_comb begin
        hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
        end
    end

    assign act_d = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    assign hs_d  = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
    assign vs_d  = (vcnt_q >= VS_START) && (vcnt_q < VS_END);

    // Divide by the scale factor of 4. Outside the active window the
    // address is parked at 0 so it never runs past the end of the buffer.
    assign w_row     = vcnt_q[9:2];
    assign w_col     = hcnt_q[9:2];
    assign w_rd_addr = act_d ? (({7'd0, w_row} << 7) + ({7'd0, w_row} << 5) + {7'd0, w_col})
                             : 15'd0;

    // ------------------------------------------------------------------
    // Framebuffer: one write port, one registered read port. Both use
    // non-blocking updates, so a same-clk read of a written address
    // returns the previous contents. No reset, to allow RAM inference.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[w_wr_addr[AW-1:0]] <= colour;
        end
        if (w_pix_en) begin
            rd_q <= mem_q[w_rd_addr[AW-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Pixel tick, raster counters, pipeline flags and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase_q   <= 1'b0;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            vblank_q  <= 1'b0;
            wr_drop_q <= 1'b0;
            act1_q    <= 1'b0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            rgb_q     <= '0;
            blank_q   <= 1'b0;
            hs_n_q    <= 1'b1;
            vs_n_q    <= 1'b1;
        end else begin
            phase_q   <= ~phase_q;
            wr_drop_q <= plot && !w_in_range;
            // Fires on the tick that moves the raster onto the first blank line.
            vblank_q  <= w_pix_en && (hcnt_q == H_LAST) && (vcnt_q == VBL_LINE);
            if (w_pix_en) begin
                hcnt_q  <= hcnt_d;
                vcnt_q  <= vcnt_d;
                act1_q  <= act_d;
                hs1_q   <= hs_d;
                vs1_q   <= vs_d;
                rgb_q   <= act1_q ? rd_q : 3'b000;
                blank_q <= act1_q;
                hs_n_q  <= ~hs1_q;
                vs_n_q  <= ~vs1_q;
            end
        end
    end

    assign wr_drop   = wr_drop_q;
    assign vblank    = vblank_q;
    assign VGA_CLK   = phase_q;
    assign VGA_HS    = hs_n_q;
    assign VGA_VS    = vs_n_q;
    assign VGA_BLANK = blank_q;
    assign VGA_SYNC  = 1'b1;
    assign VGA_R     = {10{rgb_q[2]}};
    assign VGA_G     = {10{rgb_q[1]}};
    assign VGA_B     = {10{rgb_q[0]}};

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_scanout
//  Description : Directed testbench for vga_scanout. The vertical timing is
//                shortened (8 active lines, 2-row framebuffer) so several
//                frames fit in a short run; horizontal timing is the default.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_scanout;

    localparam int VA          = 8;
    localparam int VFP         = 1;
    localparam int VSY         = 2;
    localparam int VBP         = 1;
    localparam int FBH         = 2;
    localparam int VT          = VA + VFP + VSY + VBP;
    localparam int FRAME_TICKS = 800 * VT;
    localparam int FRAME_CLK   = 2 * FRAME_TICKS;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] x      = '0;
    logic [6:0] y      = '0;
    logic [2:0] colour = '0;
    logic       plot   = 1'b0;

    logic       wr_drop, vblank, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC;
    logic [9:0] VGA_R, VGA_G, VGA_B;

    vga_scanout #(
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VSY),
        .V_BP     (VBP),
        .FB_H     (FBH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .wr_drop   (wr_drop),
        .vblank    (vblank),
        .VGA_CLK   (VGA_CLK),
        .VGA_HS    (VGA_HS),
        .VGA_VS    (VGA_VS),
        .VGA_BLANK (VGA_BLANK),
        .VGA_SYNC  (VGA_SYNC),
        .VGA_R     (VGA_R),
        .VGA_G     (VGA_G),
        .VGA_B     (VGA_B)
    );

    always #10 clk = ~clk;

    // n = number of rising edges since reset release.
    int n = 0;
    always @(posedge clk) begin
        if (!resetn) n <= 0;
        else         n <= n + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (n=%0d)", tag, got, exp, n);
        end
    endtask

    function automatic logic [31:0] rgb_word(input logic [2:0] c);
        return {2'b00, {10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
    endfunction

    task automatic wait_n(input int t);
        if (n > t) check_val("schedule_late", n, t);
        while (n < t) @(negedge clk);
    endtask

    // Pixel tick p is on the outputs for edges 2p+4 and 2p+5 after release.
    task automatic check_pix(input string tag, input int f, input int v, input int h,
                             input logic [2:0] c, input logic bl);
        wait_n(2 * (f * FRAME_TICKS + v * 800 + h) + 4);
        check_val({tag, "_rgb"}, {2'b00, VGA_R, VGA_G, VGA_B}, rgb_word(c));
        check_val({tag, "_blank"}, VGA_BLANK, bl);
        check_val({tag, "_vgaclk"}, VGA_CLK, n % 2);
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_hs"}, VGA_HS, 1);
        check_val({tag, "_vs"}, VGA_VS, 1);
        check_val({tag, "_blank"}, VGA_BLANK, 0);
        check_val({tag, "_rgb"}, {2'b00, VGA_R, VGA_G, VGA_B}, 0);
        check_val({tag, "_wr_drop"}, wr_drop, 0);
        check_val({tag, "_vblank"}, vblank, 0);
        check_val({tag, "_vgaclk"}, VGA_CLK, 0);
        check_val({tag, "_sync"}, VGA_SYNC, 1);
    endtask

    task automatic put(input int xx, input int yy, input int cc);
        x      = 8'(xx);
        y      = 7'(yy);
        colour = 3'(cc);
        plot   = 1'b1;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Timing monitor: sync edges, blank runs, vblank pulses
    // ------------------------------------------------------------------
    int   hs_last, hs_falls, vs_last, vs_falls, blank_run, blank_lines, vb_cnt, vb_total;
    logic hs_p, vs_p, bl_p, vb_p;

    always @(negedge clk) begin
        if (!resetn) begin
            hs_p = 1'b1; vs_p = 1'b1; bl_p = 1'b0; vb_p = 1'b0;
            hs_falls = 0; vs_falls = 0; blank_run = 0; blank_lines = 0;
            vb_cnt = 0; vb_total = 0; hs_last = 0; vs_last = 0;
        end else begin
            if (hs_p && !VGA_HS) begin
                if (hs_falls == 0) check_val("hs_first_fall", n, 1316);
                else               check_val("hs_period", n - hs_last, 1600);
                hs_last = n;
                hs_falls++;
            end
            if (!hs_p && VGA_HS) check_val("hs_low", n - hs_last, 192);

            if (vs_p && !VGA_VS) begin
                if (vs_falls == 0) check_val("vs_first_fall", n, 2 * 800 * (VA + VFP) + 4);
                else               check_val("vs_period", n - vs_last, FRAME_CLK);
                check_val("lines_per_frame", blank_lines, VA);
                check_val("vblank_per_frame", vb_cnt, 1);
                blank_lines = 0;
                vb_cnt      = 0;
                vs_last     = n;
                vs_falls++;
            end
            if (!vs_p && VGA_VS) check_val("vs_low", n - vs_last, 3200);

            if (VGA_BLANK) blank_run++;
            if (bl_p && !VGA_BLANK) begin
                check_val("blank_run", blank_run, 1280);
                blank_lines++;
            end
            if (!VGA_BLANK) blank_run = 0;

            if (vblank) begin
                check_val("vblank_width", vb_p, 0);
                check_val("vblank_pos", (n - 1600 * VA) % FRAME_CLK, 0);
                vb_cnt++;
                vb_total++;
            end

            hs_p = VGA_HS; vs_p = VGA_VS; bl_p = VGA_BLANK; vb_p = vblank;
        end
    end

    // ------------------------------------------------------------------
    // Directed pixel expectations for frame 1 (time-ordered)
    // ------------------------------------------------------------------
    typedef struct {
        int         v;
        int         h;
        logic [2:0] c;
        logic       bl;
    } vec_t;

    vec_t tbl [13] = '{
        '{0,   0, 3'b100, 1'b1},
        '{0,   4, 3'b011, 1'b1},
        '{0,   8, 3'b000, 1'b1},
        '{3,   3, 3'b100, 1'b1},
        '{3,   7, 3'b011, 1'b1},
        '{3, 639, 3'b000, 1'b1},
        '{4,   0, 3'b000, 1'b1},
        '{4, 636, 3'b111, 1'b1},
        '{7,   3, 3'b000, 1'b1},
        '{7, 635, 3'b000, 1'b1},
        '{7, 639, 3'b111, 1'b1},
        '{7, 640, 3'b000, 1'b0},
        '{8,   0, 3'b000, 1'b0}
    };

    initial begin
        int drops;
        int a;
        logic [2:0] e;

        // Reset state
        resetn = 1'b0;
        repeat (5) @(negedge clk);
        check_reset("rst0");
        resetn = 1'b1;

        // Bring the framebuffer to a known all-zero state
        drops = 0;
        for (int i = 0; i < 160 * FBH; i++) begin
            put(i % 160, i / 160, 0);
            drops += int'(wr_drop);
        end
        check_val("clear_drops", drops, 0);

        // Pattern, corner and out-of-range writes
        put(0, 0, 3'b100);          check_val("wr_a", wr_drop, 0);
        put(1, 0, 3'b011);          check_val("wr_b", wr_drop, 0);
        put(159, FBH - 1, 3'b111);  check_val("wr_corner", wr_drop, 0);
        put(160, 0, 3'b111);        check_val("drop_x160", wr_drop, 1);
        put(0, FBH, 3'b111);        check_val("drop_y_edge", wr_drop, 1);
        put(0, 120, 3'b111);        check_val("drop_y120", wr_drop, 1);
        put(159, FBH - 1, 3'b111);  check_val("wr_edge_ok", wr_drop, 0);
        plot = 1'b0;
        @(negedge clk);
        check_val("drop_idle", wr_drop, 0);

        // Frame 1: scaled pixels, corner, blanking, dropped write absent
        for (int i = 0; i < 13; i++) begin
            check_pix($sformatf("f1_v%0d_h%0d", tbl[i].v, tbl[i].h), 1,
                      tbl[i].v, tbl[i].h, tbl[i].c, tbl[i].bl);
        end

        // Sweep every address with colour = addr[2:0] during vertical blank
        drops = 0;
        for (int i = 0; i < 160 * FBH; i++) begin
            put(i % 160, i / 160, i % 8);
            drops += int'(wr_drop);
        end
        plot = 1'b0;
        check_val("sweep_drops", drops, 0);

        // Frame 2 must show the swept pattern on every visible pixel
        for (int v = 0; v < VA; v++) begin
            for (int h = 0; h < 640; h++) begin
                a = (v / 4) * 160 + h / 4;
                e = a[2:0];
                wait_n(2 * (2 * FRAME_TICKS + v * 800 + h) + 4);
                check_val("f2_pixel", {2'b00, VGA_R, VGA_G, VGA_B}, rgb_word(e));
            end
        end
        check_val("vs_falls_total", vs_falls, 2);
        check_val("vblank_total", vb_total, 2);

        // Mid-frame reset restarts the raster at (0,0)
        resetn = 1'b0;
        repeat (5) @(negedge clk);
        check_reset("rst_mid");
        resetn = 1'b1;
        check_pix("restart_h0", 0, 0, 0, 3'b000, 1'b1);
        check_pix("restart_h4", 0, 0, 4, 3'b001, 1'b1);
        wait_n(1400);
        check_val("hs_after_rst", hs_falls, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
